// File: rtl/sw_seq_feeder.sv
// Host-side feeder that streams a reference/query sequence pair into the Smith-Waterman
// accelerator and latches its result. Define SW_FEEDER_TIMEOUT_EN to bound the WAIT state.
module sw_seq_feeder #(
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int LEN_REF         = 64,
    parameter int LEN_QUERY       = 48,
    parameter int TIMEOUT_CYCLES  = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [5:0]                 wr_addr,
    input  logic [1:0]                 wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       valid,
    output logic [1:0]                 data_ref,
    output logic [1:0]                 data_query,
    input  logic                       finish,
    input  logic [WIDTH_SCORE-1:0]     max,
    input  logic [WIDTH_POS_REF-1:0]   pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] pos_query,
    output logic                       done,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
    output logic                       timeout
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    localparam int CW = $clog2(LEN_REF);
    localparam logic [CW-1:0] CNT_LAST     = CW'(LEN_REF - 1);
    localparam logic [CW:0]   QRY_RD_LIM   = (CW + 1)'(LEN_QUERY);
    localparam logic [6:0]    REF_WR_LIM   = 7'(LEN_REF);
    localparam logic [6:0]    QRY_WR_LIM   = 7'(LEN_QUERY);

    logic [1:0] ref_mem [LEN_REF];
    logic [1:0] qry_mem [LEN_QUERY];

    state_t                     state_reg, state_next;
    logic [CW-1:0]              cnt_reg, cnt_next;
    logic                       timeout_hit;
    logic                       valid_reg;
    logic [1:0]                 data_ref_reg, data_query_reg;
    logic [WIDTH_SCORE-1:0]     res_max_reg;
    logic [WIDTH_POS_REF-1:0]   res_pos_ref_reg;
    logic [WIDTH_POS_QUERY-1:0] res_pos_query_reg;

`ifdef SW_FEEDER_TIMEOUT_EN
    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CYCLES - 1);
    logic [11:0] tmo_cnt_reg;
    logic        timeout_reg;
`endif

    // Host writes only land while idle; query addresses past the sequence length are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && state_reg == IDLE) begin
            if (!wr_sel && {1'b0, wr_addr} < REF_WR_LIM)
                ref_mem[wr_addr] <= wr_data;
            if (wr_sel && {1'b0, wr_addr} < QRY_WR_LIM)
                qry_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST)
                    state_next = WAIT;
            end
            WAIT: begin
                if (finish) begin
                    state_next = DONE;
                end
`ifdef SW_FEEDER_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Beat outputs are the registered memory read; query lane goes quiet past its length.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            data_ref_reg   <= '0;
            data_query_reg <= '0;
        end else begin
            valid_reg      <= 1'b0;
            data_ref_reg   <= '0;
            data_query_reg <= '0;
            if (state_reg == SEND) begin
                valid_reg    <= 1'b1;
                data_ref_reg <= ref_mem[cnt_reg];
                if ({1'b0, cnt_reg} < QRY_RD_LIM)
                    data_query_reg <= qry_mem[cnt_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_max_reg       <= '0;
            res_pos_ref_reg   <= '0;
            res_pos_query_reg <= '0;
        end else if (state_reg == WAIT && finish) begin
            res_max_reg       <= max;
            res_pos_ref_reg   <= pos_ref;
            res_pos_query_reg <= pos_query;
        end else if (timeout_hit) begin
            res_max_reg       <= '0;
            res_pos_ref_reg   <= '0;
            res_pos_query_reg <= '0;
        end
    end

`ifdef SW_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state_reg != WAIT)
                tmo_cnt_reg <= '0;
            else
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            if (state_reg == IDLE && start)
                timeout_reg <= 1'b0;
            else if (timeout_hit)
                timeout_reg <= 1'b1;
        end
    end
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign valid         = valid_reg;
    assign data_ref      = data_ref_reg;
    assign data_query    = data_query_reg;
    assign res_max       = res_max_reg;
    assign res_pos_ref   = res_pos_ref_reg;
    assign res_pos_query = res_pos_query_reg;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Randomized self-checking bench for sw_seq_feeder against a sequence-level reference model.
module tb_sw_seq_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [7:0] max_in = '0;
    logic [6:0] pos_ref_in = '0;
    logic [5:0] pos_query_in = '0;
    logic       busy, valid, done, timeout;
    logic [1:0] data_ref, data_query;
    logic [7:0] res_max;
    logic [6:0] res_pos_ref;
    logic [5:0] res_pos_query;

    sw_seq_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .valid(valid), .data_ref(data_ref),
        .data_query(data_query), .finish(finish), .max(max_in), .pos_ref(pos_ref_in),
        .pos_query(pos_query_in), .done(done), .res_max(res_max), .res_pos_ref(res_pos_ref),
        .res_pos_query(res_pos_query), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0] ref_m [64];
    logic [1:0] qry_m [48];
    logic [7:0] exp_max = '0;
    logic [6:0] exp_pr = '0;
    logic [5:0] exp_pq = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-time host write; model drops query writes past the sequence length.
    task automatic write_sym(input bit sel, input int addr, input logic [1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!sel) ref_m[addr] = d;
        else if (addr < 48) qry_m[addr] = d;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_res_max"}, 32'(res_max), 32'(exp_max));
        check({tag, "_res_pos_ref"}, 32'(res_pos_ref), 32'(exp_pr));
        check({tag, "_res_pos_query"}, 32'(res_pos_query), 32'(exp_pq));
    endtask

    // One job: start, 64 beats, WAIT; optionally finish, inject ignored inputs, or reset mid-SEND.
    task automatic run_job(input int job, input bit do_finish, input bit inject, input int reset_at);
        logic [1:0] exp_q;
        int w;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_timeout_clr", 32'(timeout), 32'd0);
        for (int b = 0; b < 64; b++) begin
            if (b == reset_at) begin
                reset = 1'b1;
                tick();
                check("rst_valid", 32'(valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                exp_max = '0; exp_pr = '0; exp_pq = '0;
                check_results("rst");
                tick();
                reset = 1'b0;
                $display("job %0d reset at beat %0d", job, b);
                return;
            end
            if (inject && b == 10) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd5; wr_data = ~ref_m[5];
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
            exp_q = (b < 48) ? qry_m[b] : 2'd0;
            check($sformatf("beat%0d_valid", b), 32'(valid), 32'd1);
            check($sformatf("beat%0d_data", b), {28'd0, data_ref, data_query}, {28'd0, ref_m[b], exp_q});
        end
        tick();
        check("wait_valid_low", 32'(valid), 32'd0);
        check("wait_data_low", {28'd0, data_ref, data_query}, 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        if (!do_finish) return;
        w = $urandom_range(0, 4);
        for (int i = 0; i < w; i++) begin
            if (inject && i == 0) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd5; wr_data = ~ref_m[5];
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
            check("wait_hold_valid", 32'(valid), 32'd0);
            check("wait_hold_done", 32'(done), 32'd0);
        end
        exp_max = 8'($urandom_range(0, 255));
        exp_pr = 7'($urandom_range(0, 64));
        exp_pq = 6'($urandom_range(0, 48));
        if (job == 1) begin
            exp_max = 8'd96; exp_pr = 7'd64; exp_pq = 6'd48;
        end
        finish = 1'b1; max_in = exp_max; pos_ref_in = exp_pr; pos_query_in = exp_pq;
        tick();
        finish = 1'b0; max_in = ~exp_max; pos_ref_in = ~exp_pr; pos_query_in = ~exp_pq;
        check("done_pulse", 32'(done), 32'd1);
        check_results("capture");
        tick();
        check("done_single", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check_results("hold");
        $display("job %0d max=%0d pos_ref=%0d pos_query=%0d wait=%0d", job, res_max, res_pos_ref, res_pos_query, w);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check_results("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 64; i++) write_sym(1'b0, i, 2'(i % 4));
        for (int j = 0; j < 48; j++) write_sym(1'b1, j, 2'((3 - j) % 4));
        run_job(1, 1'b1, 1'b0, -1);

        // finish outside WAIT must not produce a result
        finish = 1'b1; max_in = 8'hAA;
        tick();
        tick();
        finish = 1'b0;
        check("idle_finish_done", 32'(done), 32'd0);
        check("idle_finish_busy", 32'(busy), 32'd0);
        check_results("idle_finish");

        run_job(2, 1'b1, 1'b1, -1);
        run_job(3, 1'b0, 1'b0, 20);
        run_job(4, 1'b1, 1'b0, -1);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 1) == 0) write_sym(1'b0, $urandom_range(0, 63), 2'($urandom));
                else write_sym(1'b1, $urandom_range(0, 63), 2'($urandom));
            end
            write_sym(1'b1, 50, ~qry_m[2]);
            run_job(5 + k, 1'b1, 1'(k), -1);
        end

        // no finish: WAIT either times out or hangs, depending on build
        run_job(8, 1'b0, 1'b0, -1);
        n = 1;
        while (done !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
`ifdef SW_FEEDER_TIMEOUT_EN
        check("timeout_cycles", 32'(n), 32'd4095);
        check("timeout_flag", 32'(timeout), 32'd1);
        exp_max = '0; exp_pr = '0; exp_pq = '0;
        check_results("timeout");
        tick();
        check("timeout_idle", 32'(busy), 32'd0);
        run_job(9, 1'b1, 1'b0, -1);
`else
        check("no_timeout_busy", 32'(busy), 32'd1);
        check("no_timeout_done", 32'(done), 32'd0);
        check("no_timeout_flag", 32'(timeout), 32'd0);
`endif
        $display("job 8 waited %0d cycles without finish", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
